// File: rtl/route_arb_1536.sv
// route_arb_1536: round-robin arbiter that shares one wide AXI-Stream sink
// (the 1536-to-128 downsizer) between NUM_SRC producers. A grant lasts up to
// len_q input beats or until the source's tlast, whichever comes first.
// The granted stream is a zero-latency combinational pass-through, tagged
// with the source index on m_axis_tid.

module route_arb_1536 #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 1536,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LEN_W-1:0]          burst_len,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  input  logic                      m_axis_tready,
  output logic                      busy
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  // Registered state
  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

  // Combinational helpers
  logic              xfer;
  logic              any_req;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              last_beat;
  logic              hs;

  assign xfer    = (state_q == StXfer);
  assign any_req = |s_axis_tvalid;

  // Round-robin pick: scan sources starting one past the previous winner.
  always_comb begin
    int cand;
    winner = last_grant_q;
    found  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= int'(NUM_SRC); k++) begin
      cand = (int'(last_grant_q) + k) % int'(NUM_SRC);
      for (int j = 0; j < int'(NUM_SRC); j++) begin
        if (!found && (j == cand) && s_axis_tvalid[j]) begin
          winner = ID_W'(j);
          found  = 1'b1;
        end
      end
    end
  end

  // Select the granted source's valid, last and data lanes.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < int'(NUM_SRC); j++) begin
      if (grant_q == ID_W'(j)) begin
        sel_valid = s_axis_tvalid[j];
        sel_last  = s_axis_tlast[j];
        sel_data  = s_axis_tdata[j*DATA_W +: DATA_W];
      end
    end
  end

  // len_q is never 0, so len_q-1 cannot underflow.
  assign last_beat = (beat_cnt_q == (len_q - LEN_W'(1)));

  // Output pass-through; everything is forced to 0 outside a grant.
  always_comb begin
    m_axis_tvalid = xfer & sel_valid;
    m_axis_tlast  = xfer & sel_valid & (sel_last | last_beat);
    m_axis_tdata  = xfer ? sel_data : '0;
    m_axis_tid    = xfer ? grant_q : '0;
    busy          = xfer;
  end

  // Only the granted source ever sees ready.
  always_comb begin
    s_axis_tready = '0;
    for (int j = 0; j < int'(NUM_SRC); j++) begin
      s_axis_tready[j] = xfer & m_axis_tready & (grant_q == ID_W'(j));
    end
  end

  assign hs = m_axis_tvalid & m_axis_tready;

  // Next-state: arbitrate in idle, count beats and end the grant in transfer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d      = StXfer;
          grant_d      = winner;
          last_grant_d = winner;
          len_d        = (burst_len == '0) ? LEN_W'(1) : burst_len;
          beat_cnt_d   = '0;
        end
      end
      StXfer: begin
        if (hs) begin
          if (m_axis_tlast) begin
            // tlast and the length limit on the same beat end the grant once.
            state_d    = StIdle;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; last_grant resets to NUM_SRC-1 so source 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      len_q        <= LEN_W'(1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_route_arb_1536.sv
// Testbench for route_arb_1536: directed vector table, hand-written corner
// sequences and a randomized run against a grant-level reference model.

module tb_route_arb_1536;

  localparam int N  = 4;
  localparam int DW = 1536;
  localparam int LW = 8;
  localparam int IW = 3;

  logic            clk;
  logic            rst_n;
  logic [LW-1:0]   burst_len;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic [IW-1:0]   m_axis_tid;
  logic            m_axis_tready;
  logic            busy;

  route_arb_1536 #(
    .NUM_SRC(N),
    .DATA_W (DW),
    .LEN_W  (LW),
    .ID_W   (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .burst_len    (burst_len),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tready(m_axis_tready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] exp);
    checks++;
    if (m_axis_tdata !== exp) begin
      errors++;
      $display("FAIL %s: got low64 %h expected low64 %h at %0t", name,
               m_axis_tdata[63:0], exp[63:0], $time);
    end
  endtask

  // Reference model: which source holds the grant (-1 = none), the previous
  // winner, and how many beats the grant may still pass.
  int m_src;
  int m_rr;
  int m_left;
  logic e_v;
  logic e_l;

  task automatic model_reset();
    m_src  = -1;
    m_rr   = N - 1;
    m_left = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N * DW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
    chk({tag, "_tid"},    64'(m_axis_tid),    64'd0);
    chk({tag, "_busy"},   64'(busy),          64'd0);
    chk_data({tag, "_tdata"}, '0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    burst_len     = '0;
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle checked against the model. Called at a falling edge.
  task automatic cycle(input logic [N-1:0] vld, input logic [N-1:0] lst, input logic rdy,
                       input logic [LW-1:0] blen);
    logic [N-1:0]  e_rdy;
    logic [N-1:0]  sh;
    logic [DW-1:0] e_d;
    int            w;
    s_axis_tvalid = vld;
    s_axis_tlast  = lst;
    m_axis_tready = rdy;
    burst_len     = blen;
    #1;
    if (m_src < 0) begin
      e_rdy = '0;
      e_v   = 1'b0;
      e_l   = 1'b0;
      e_d   = '0;
    end else begin
      sh    = vld >> m_src;
      e_v   = sh[0];
      sh    = lst >> m_src;
      e_l   = e_v & (sh[0] | (m_left == 1));
      e_rdy = rdy ? (N'(1) << m_src) : '0;
      e_d   = DW'(s_axis_tdata >> (m_src * DW));
    end
    chk("tready", 64'(s_axis_tready), 64'(e_rdy));
    chk("tready_onehot", 64'($countones(s_axis_tready) <= 1), 64'd1);
    chk("tvalid", 64'(m_axis_tvalid), 64'(e_v));
    chk("tlast", 64'(m_axis_tlast), 64'(e_l));
    chk("tid", 64'(m_axis_tid), (m_src < 0) ? 64'd0 : 64'(m_src));
    chk("busy", 64'(busy), 64'(m_src >= 0));
    chk_data("tdata", e_d);
    @(posedge clk);
    if (m_src < 0) begin
      if (vld != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          int c;
          c  = (m_rr + k) % N;
          sh = vld >> c;
          if (w < 0 && sh[0]) w = c;
        end
        m_src  = w;
        m_rr   = w;
        m_left = (blen == 0) ? 1 : int'(blen);
      end
    end else if (e_v && rdy) begin
      if (e_l) m_src = -1;
      else m_left--;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0]  vld;
    logic [N-1:0]  lst;
    logic          rdy;
    logic [LW-1:0] blen;
    logic [N-1:0]  e_rdy;
    logic          e_v;
    logic          e_l;
    logic [IW-1:0] e_tid;
    logic          e_busy;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] vld, input logic [N-1:0] lst, input logic rdy,
                              input logic [LW-1:0] blen, input logic [N-1:0] e_rdy,
                              input logic e_v, input logic e_l, input logic [IW-1:0] e_tid,
                              input logic e_busy);
    vec_t v;
    v.vld = vld; v.lst = lst; v.rdy = rdy; v.blen = blen;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_l = e_l; v.e_tid = e_tid; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int hs_cnt;
    int seen_last;
    logic started;
    logic [DW-1:0] exp_d;
    logic [LW-1:0] bl;
    int r;

    // Directed table: burst of 4 from source 0, burst_len 0 alternation
    // between sources 0 and 3, early tlast from source 2 then handoff to 3.
    tbl.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd4, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd4, 4'b0001, 1'b1, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd4, 4'b0001, 1'b1, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd4, 4'b0001, 1'b1, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd4, 4'b0001, 1'b1, 1'b1, 3'd0, 1'b1));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 8'd4, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 8'd4, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'd0, 4'b1000, 1'b1, 1'b1, 3'd3, 1'b1));
    tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'd0, 4'b0001, 1'b1, 1'b1, 3'd0, 1'b1));
    tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'd0, 4'b1000, 1'b1, 1'b1, 3'd3, 1'b1));
    tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'd0, 4'b0001, 1'b1, 1'b1, 3'd0, 1'b1));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 8'd8, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd8, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd8, 4'b0100, 1'b1, 1'b0, 3'd2, 1'b1));
    tbl.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd8, 4'b0100, 1'b1, 1'b0, 3'd2, 1'b1));
    tbl.push_back(mk(4'b0100, 4'b0100, 1'b1, 8'd8, 4'b0100, 1'b1, 1'b1, 3'd2, 1'b1));
    tbl.push_back(mk(4'b1101, 4'b0000, 1'b1, 8'd8, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(4'b1101, 4'b0000, 1'b1, 8'd8, 4'b1000, 1'b1, 1'b0, 3'd3, 1'b1));

    do_reset();
    for (int i = 0; i < N; i++) s_axis_tdata[i*DW +: DW] = {48{32'hC0DE_0000 | 32'(i)}};
    for (int i = 0; i < tbl.size(); i++) begin
      s_axis_tvalid = tbl[i].vld;
      s_axis_tlast  = tbl[i].lst;
      m_axis_tready = tbl[i].rdy;
      burst_len     = tbl[i].blen;
      #1;
      exp_d = tbl[i].e_busy ? DW'(s_axis_tdata >> (int'(tbl[i].e_tid) * DW)) : '0;
      chk($sformatf("vec%0d_tready", i), 64'(s_axis_tready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_tvalid", i), 64'(m_axis_tvalid), 64'(tbl[i].e_v));
      chk($sformatf("vec%0d_tlast", i), 64'(m_axis_tlast), 64'(tbl[i].e_l));
      chk($sformatf("vec%0d_tid", i), 64'(m_axis_tid), 64'(tbl[i].e_tid));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      chk_data($sformatf("vec%0d_tdata", i), exp_d);
      @(negedge clk);
    end

    // Source 1, burst of 5, ready toggling 1,0,0,1 and valid dropped twice.
    do_reset();
    hs_cnt    = 0;
    seen_last = 0;
    started   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      logic [N-1:0] v;
      logic rd;
      if (started && m_src < 0) break;
      v  = (c == 0) ? 4'b0010 : ((c == 4 || c == 5) ? 4'b1101 : 4'b1111);
      rd = (c == 0) ? 1'b1 : (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3));
      rand_data();
      s_axis_tvalid = v;
      m_axis_tready = rd;
      #1;
      if (busy && m_axis_tid == 3'd1 && m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        if (m_axis_tlast) seen_last = hs_cnt;
      end
      #1;
      cycle(v, 4'b0000, rd, 8'd5);
      if (m_src == 1) started = 1'b1;
    end
    chk("stall_handshakes", 64'(hs_cnt), 64'd5);
    chk("stall_tlast_beat", 64'(seen_last), 64'd5);

    // Reset asserted during beat 3 of a 6-beat burst from source 3.
    do_reset();
    rand_data();
    cycle(4'b1000, 4'b0000, 1'b1, 8'd6);
    cycle(4'b1000, 4'b0000, 1'b1, 8'd6);
    cycle(4'b1000, 4'b0000, 1'b1, 8'd6);
    s_axis_tvalid = 4'b1000;
    #1;
    chk("beat3_busy", 64'(busy), 64'd1);
    chk("beat3_tid", 64'(m_axis_tid), 64'd3);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midburst_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1001, 4'b0000, 1'b1, 8'd6);
    chk("post_reset_grant", 64'(m_axis_tid), 64'd0);
    cycle(4'b1001, 4'b0000, 1'b1, 8'd6);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      logic [N-1:0] l;
      r = int'($urandom_range(0, 15));
      if (r == 0) bl = 8'd0;
      else if (r == 1) bl = 8'd255;
      else bl = LW'($urandom_range(1, 6));
      v = N'($urandom);
      l = (($urandom % 4) == 0) ? N'($urandom) : '0;
      rand_data();
      cycle(v, l, (($urandom % 4) != 0), bl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/route_arb_1536.md
# route_arb_1536

Round-robin arbiter that lets NUM_SRC independent 1536-bit AXI-Stream producers share the single 1536-to-128 downsizer in the data-route path. It grants one source at a time for a burst of up to `burst_len` input beats, or until that source's `tlast`. It passes the granted stream through with zero added data latency and tags it with a source ID, so downstream routing can steer the 128-bit output words.

## Interface
Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- DATA_W, 1536, stream data width
- LEN_W, 8, width of burst length configuration
- ID_W, 3, width of source ID output (≥ clog2(NUM_SRC))

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- burst_len  in  LEN_W  max input beats per grant; sampled at grant; 0 treated as 1
- s_axis_tdata  in  NUM_SRC*DATA_W  source data, source i at bits [i*DATA_W +: DATA_W]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tlast  in  NUM_SRC  per-source end-of-packet
- s_axis_tready  out  NUM_SRC  per-source ready; at most one bit set
- m_axis_tdata  out  DATA_W  granted source data, to downsizer input
- m_axis_tvalid  out  1  granted source valid
- m_axis_tlast  out  1  final beat of current grant
- m_axis_tid  out  ID_W  index of granted source
- m_axis_tready  in  1  downsizer ready
- busy  out  1  high while a grant is held

## Operation
- States: IDLE, XFER.
- IDLE:
  - No grant. All s_axis_tready = 0, m_axis_tvalid = 0, busy = 0.
  - If any s_axis_tvalid is set, pick the winner by round-robin. Search order starts at last_grant+1 modulo NUM_SRC.
  - Register grant = winner, last_grant = winner, len_q = max(burst_len, 1), beat_cnt = 0. Go to XFER.
- XFER, combinational pass-through of source g = grant:
  - m_axis_tdata = slice g
  - m_axis_tvalid = s_axis_tvalid[g]
  - s_axis_tready[g] = m_axis_tready; all other tready bits are 0
  - m_axis_tid = g, busy = 1
  - m_axis_tlast = s_axis_tvalid[g] & (s_axis_tlast[g] | beat_cnt == len_q-1)
- Handshake = m_axis_tvalid & m_axis_tready.
  - On a handshake with m_axis_tlast = 1: go to IDLE and clear beat_cnt.
  - On any other handshake: beat_cnt += 1 (LEN_W bits, never wraps because it ends at len_q-1).
- A granted source that drops valid mid-burst keeps the grant. There is no timeout; the arbiter waits.
- Non-granted sources never see ready, so their data is held by AXI rules.
- burst_len changes during XFER have no effect until the next grant.
- m_axis_tdata and m_axis_tid are 0 in IDLE.

## Timing
- Reset (rst_n low, any time, including mid-burst):
  - state = IDLE, grant = 0, last_grant = NUM_SRC-1 (so source 0 has first priority), beat_cnt = 0, len_q = 1.
  - All outputs 0.
  - Takes effect asynchronously. Deassertion is synchronised externally.
- Arbitration latency is 1 cycle: a valid seen in IDLE at edge N gives the grant, and that source's ready, in the cycle after edge N.
- Data path latency is 0 cycles (combinational mux from inputs to m_axis_*).
- One bubble cycle in IDLE between consecutive grants, even if requests are pending. Peak throughput is len_q/(len_q+1) of input beats.
- Simultaneous requests in IDLE: exactly one winner per round-robin order; losers wait.
- tlast on the same beat that reaches len_q-1: a single end of grant, no double count.
- len_q = 1: every grant is exactly one beat.
- burst_len = 2^LEN_W-1 gives the maximum burst of 255 beats.
- Back-pressure: m_axis_tready low holds beat_cnt and state. The output mirrors the source, so the source holds its data stable.

## Test plan
- Reset, then source 0 only, valid with burst_len = 4, m_axis_tready = 1 → IDLE bubble one cycle, then 4 beats with m_axis_tid = 0. m_axis_tlast is set on beat 4 only, then one IDLE cycle.
- All 4 sources valid continuously, burst_len = 2 → grant order 0,1,2,3,0,… Each grant is 2 beats with a 1-cycle gap. s_axis_tready is one-hot or zero every cycle.
- Source 2, burst_len = 8, s_axis_tlast on beat 3 → grant ends after 3 beats with m_axis_tlast on beat 3. The next grant goes to the next requesting source after 2.
- Source 1 granted, burst_len = 5, m_axis_tready toggled 1,0,0,1,… and source valid dropped for 2 cycles mid-burst → exactly 5 handshakes and beat_cnt frozen during stalls. No other source gets ready.
- burst_len = 0 with sources 0 and 3 requesting → 1-beat grants alternating 0,3,0,3 with tlast on every beat.
- rst_n pulsed low during beat 3 of a 6-beat burst from source 3 → all outputs 0 immediately. After release the first grant goes to source 0 if it is requesting.
